// File: rtl/riesgos_pkg.sv
// Shared definitions for the hazard-control unit of the 5-stage MIPS pipeline.
// Contents: FSM state encoding, register-index width, default drain length
// and the operand-match helper used by the stall detector.
package riesgos_pkg;

  localparam int REG_W            = 5;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } estado_e;

  // A producer register r feeds the ID instruction when it is not $zero and
  // equals a source register that the instruction actually reads.
  function automatic logic reg_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             usa_rs,
    input logic             usa_rt
  );
    return (r != {REG_W{1'b0}}) && (((r == rs) && usa_rs) || ((r == rt) && usa_rt));
  endfunction

endpackage

// File: rtl/riesgos_detector.sv
// Combinational stall detector.
// Inputs : ID source registers and their use flags, ID branch flag,
//          EX MemRead/RegWrite/rd, MEM MemRead/rd.
// Output : o_stall, high whenever the ID instruction must wait one cycle.
module riesgos_detector
  import riesgos_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_usa_rs,
  input  logic             i_id_usa_rt,
  input  logic             i_id_branch,
  input  logic             i_ex_memread,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_mem_memread,
  input  logic [REG_W-1:0] i_mem_rd,
  output logic             o_stall
);

  logic match_ex;
  logic match_mem;

  assign match_ex  = reg_match(i_ex_rd,  i_id_rs, i_id_rt, i_id_usa_rs, i_id_usa_rt);
  assign match_mem = reg_match(i_mem_rd, i_id_rs, i_id_rt, i_id_usa_rs, i_id_usa_rt);

  // Load-use always stalls; branches resolve in ID, so they also wait for an
  // ALU result in EX and for a load still in MEM (giving load->branch 2 cycles).
  assign o_stall = (i_ex_memread && match_ex)
                 || (i_id_branch && i_ex_regwrite && match_ex)
                 || (i_id_branch && i_mem_memread && match_mem);

endmodule

// File: rtl/unidad_riesgos_ctrl.sv
// Hazard-control unit: drives the ID bubble mux, PC and IF/ID enables and the
// IF/ID flush, sequences HALT (drain then sticky halted), keeps debug counters.
// Ports: i_clk, i_reset (sync, active low), i_enable (debug run/step),
//        ID/EX/MEM hazard inputs, o_riesgo/o_pc_write/o_ifid_write/
//        o_ifid_flush (combinational), o_halted, o_cnt_stall/flush/ciclos.
module unidad_riesgos_ctrl
  import riesgos_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_usa_rs,
  input  logic             i_id_usa_rt,
  input  logic             i_id_branch,
  input  logic             i_id_taken,
  input  logic             i_id_halt,
  input  logic             i_ex_memread,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_mem_memread,
  input  logic [REG_W-1:0] i_mem_rd,
  output logic             o_riesgo,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cnt_stall,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_ciclos
);

  localparam int               DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  estado_e          estado_q, estado_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic             stall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  riesgos_detector u_detector (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_usa_rs   (i_id_usa_rs),
    .i_id_usa_rt   (i_id_usa_rt),
    .i_id_branch   (i_id_branch),
    .i_ex_memread  (i_ex_memread),
    .i_ex_regwrite (i_ex_regwrite),
    .i_ex_rd       (i_ex_rd),
    .i_mem_memread (i_mem_memread),
    .i_mem_rd      (i_mem_rd),
    .o_stall       (stall_s)
  );

  // State register, drain counter and debug counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      estado_q <= ST_RUN;
      drain_q  <= {DW{1'b0}};
      stall_q  <= {CNT_W{1'b0}};
      flush_q  <= {CNT_W{1'b0}};
      ciclos_q <= {CNT_W{1'b0}};
    end else begin
      estado_q <= estado_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      ciclos_q <= ciclos_d;
    end
  end

  // Next state and counter updates; everything holds while disabled.
  always_comb begin
    estado_d = estado_q;
    drain_d  = drain_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    ciclos_d = ciclos_q;
    if (i_enable) begin
      case (estado_q)
        ST_RUN: begin
          ciclos_d = sat_inc(ciclos_q);
          if (stall_s) begin
            stall_d = sat_inc(stall_q);
          end else if (i_id_halt) begin
            drain_d  = DRAIN_LOAD;
            estado_d = ST_DRAIN;
          end else if (i_id_taken) begin
            flush_d = sat_inc(flush_q);
          end else begin
            flush_d = flush_q;
          end
        end
        ST_DRAIN: begin
          ciclos_d = sat_inc(ciclos_q);
          if (drain_q == {DW{1'b0}}) begin
            estado_d = ST_HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        ST_HALTED: begin
          estado_d = ST_HALTED;
        end
        default: begin
          estado_d = ST_RUN;
        end
      endcase
    end else begin
      estado_d = estado_q;
    end
  end

  // Pipeline control outputs; reset and disable force every enable low.
  always_comb begin
    o_riesgo     = 1'b0;
    o_pc_write   = 1'b0;
    o_ifid_write = 1'b0;
    o_ifid_flush = 1'b0;
    if (!i_reset || !i_enable) begin
      o_riesgo = 1'b0;
    end else begin
      case (estado_q)
        ST_RUN: begin
          if (stall_s) begin
            o_riesgo = 1'b1;
          end else if (i_id_halt) begin
            // HALT itself moves on to EX; the fetch behind it is discarded.
            o_ifid_write = 1'b1;
            o_ifid_flush = 1'b1;
          end else if (i_id_taken) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
          end
        end
        ST_DRAIN: begin
          o_riesgo     = 1'b1;
          o_ifid_write = 1'b1;
          o_ifid_flush = 1'b1;
        end
        ST_HALTED: begin
          o_riesgo = 1'b1;
        end
        default: begin
          o_riesgo = 1'b0;
        end
      endcase
    end
  end

  assign o_halted     = (estado_q == ST_HALTED);
  assign o_cnt_stall  = stall_q;
  assign o_cnt_flush  = flush_q;
  assign o_cnt_ciclos = ciclos_q;

endmodule

// File: tb/tb_unidad_riesgos_ctrl.sv
// Self-checking bench for unidad_riesgos_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level reference model.
module tb_unidad_riesgos_ctrl;

  localparam int DC    = 4;
  localparam int CW    = 6;
  localparam int SAT   = 63;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       usa_rs, usa_rt, branch, taken, halt, ex_mr, ex_rw, mem_mr;
  logic       riesgo, pc_w, ifid_w, ifid_f, halted;
  logic [CW-1:0] c_stall, c_flush, c_cyc;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_drain  = 0;   // DRAIN cycles still to go; >0 means draining
  bit m_halted = 1'b0;
  int m_st = 0, m_fl = 0, m_cy = 0;

  always #5 clk = ~clk;

  unidad_riesgos_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_usa_rs(usa_rs), .i_id_usa_rt(usa_rt),
    .i_id_branch(branch), .i_id_taken(taken), .i_id_halt(halt),
    .i_ex_memread(ex_mr), .i_ex_regwrite(ex_rw), .i_ex_rd(ex_rd),
    .i_mem_memread(mem_mr), .i_mem_rd(mem_rd),
    .o_riesgo(riesgo), .o_pc_write(pc_w), .o_ifid_write(ifid_w),
    .o_ifid_flush(ifid_f), .o_halted(halted),
    .o_cnt_stall(c_stall), .o_cnt_flush(c_flush), .o_cnt_ciclos(c_cyc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit uses(input logic [4:0] r);
    return (r != 5'd0) && ((r == id_rs && usa_rs) || (r == id_rt && usa_rt));
  endfunction

  function automatic int inc_sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Reference model: check every cycle on the falling edge, then advance.
  initial begin
    bit st;
    logic [4:0] exp_ctl;
    forever begin
      @(negedge clk);
      st = (ex_mr && uses(ex_rd)) || (branch && ex_rw && uses(ex_rd))
        || (branch && mem_mr && uses(mem_rd));
      if (!rst || !en)       exp_ctl = {4'b0000, m_halted};
      else if (m_halted)     exp_ctl = 5'b10001;
      else if (m_drain > 0)  exp_ctl = 5'b10110;
      else if (st)           exp_ctl = 5'b10000;
      else if (halt)         exp_ctl = 5'b00110;
      else if (taken)        exp_ctl = 5'b01110;
      else                   exp_ctl = 5'b01100;
      chk("model_ctl", {riesgo, pc_w, ifid_w, ifid_f, halted}, {27'd0, exp_ctl});
      chk("model_cnt_stall",  {26'd0, c_stall}, m_st);
      chk("model_cnt_flush",  {26'd0, c_flush}, m_fl);
      chk("model_cnt_ciclos", {26'd0, c_cyc},   m_cy);
      if (!rst) begin
        m_drain = 0; m_halted = 1'b0; m_st = 0; m_fl = 0; m_cy = 0;
      end else if (en && !m_halted) begin
        m_cy = inc_sat(m_cy);
        if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) m_halted = 1'b1;
        end else if (st)    m_st = inc_sat(m_st);
        else if (halt)      m_drain = DC;
        else if (taken)     m_fl = inc_sat(m_fl);
      end
    end
  end

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    usa_rs = 1'b0; usa_rt = 1'b0; branch = 1'b0; taken = 1'b0; halt = 1'b0;
    ex_mr = 1'b0; ex_rw = 1'b0; mem_mr = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, riesgo, pc_w, ifid_w, ifid_f}, {28'd0, exp});
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; clr();
    @(negedge clk);
    ctl("reset_forced_zero", 4'b0000);
    nxt(); rst = 1'b1; @(negedge clk);
    ctl("run_fetch", 4'b0110);
    chk("reset_ciclos", c_cyc, 32'd0);
    chk("reset_stall", c_stall, 32'd0);
    // load-use
    nxt(); ex_mr = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; usa_rs = 1'b1; @(negedge clk);
    ctl("load_use_stall", 4'b1000);
    nxt(); clr(); @(negedge clk);
    chk("load_use_cnt", c_stall, 32'd1);
    nxt(); ex_mr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; usa_rs = 1'b1; @(negedge clk);
    ctl("zero_reg_no_stall", 4'b0110);
    // load -> branch: two stall cycles
    nxt(); clr(); ex_mr = 1'b1; ex_rd = 5'd5; branch = 1'b1; id_rt = 5'd5; usa_rt = 1'b1;
    @(negedge clk); ctl("ld_br_stall1", 4'b1000);
    nxt(); ex_mr = 1'b0; ex_rd = 5'd0; mem_mr = 1'b1; mem_rd = 5'd5;
    @(negedge clk); ctl("ld_br_stall2", 4'b1000);
    nxt(); clr(); @(negedge clk);
    chk("ld_br_cnt", c_stall, 32'd3);
    // ALU -> branch: one stall cycle
    nxt(); ex_rw = 1'b1; ex_rd = 5'd7; branch = 1'b1; id_rs = 5'd7; usa_rs = 1'b1;
    @(negedge clk); ctl("alu_br_stall", 4'b1000);
    nxt(); ex_rw = 1'b0; ex_rd = 5'd0; mem_rd = 5'd7;
    @(negedge clk); ctl("alu_br_go", 4'b0110);
    chk("alu_br_cnt", c_stall, 32'd4);
    // taken branch
    nxt(); clr(); branch = 1'b1; taken = 1'b1; @(negedge clk);
    ctl("taken_flush", 4'b0111);
    nxt(); clr(); @(negedge clk);
    chk("taken_cnt", c_flush, 32'd1);
    // taken while stalled, then disabled during the stall
    nxt(); ex_mr = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; usa_rs = 1'b1; branch = 1'b1; taken = 1'b1;
    @(negedge clk); ctl("taken_stalled", 4'b1000);
    nxt(); en = 1'b0; @(negedge clk);
    ctl("disabled_stall", 4'b0000);
    chk("disabled_hold", c_stall, 32'd5);
    nxt(); en = 1'b1; @(negedge clk); ctl("stall_resume", 4'b1000);
    nxt(); clr(); @(negedge clk);
    chk("stall_cnt_after", c_stall, 32'd6);
    chk("flush_unchanged", c_flush, 32'd1);
    // HALT and drain, with a hazard that must be ignored and an enable gap
    nxt(); halt = 1'b1; @(negedge clk); ctl("halt_cycle", 4'b0011);
    nxt(); clr(); ex_mr = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; usa_rs = 1'b1;
    @(negedge clk); ctl("drain1", 4'b1011);
    nxt(); clr(); @(negedge clk); ctl("drain2", 4'b1011);
    nxt(); en = 1'b0; @(negedge clk); ctl("drain_disabled", 4'b0000);
    chk("drain_not_halted", halted, 32'd0);
    nxt(); @(negedge clk);
    nxt(); en = 1'b1; @(negedge clk); ctl("drain3", 4'b1011);
    nxt(); @(negedge clk); ctl("drain4", 4'b1011);
    chk("drain4_not_halted", halted, 32'd0);
    nxt(); @(negedge clk); ctl("halted_ctl", 4'b1000);
    chk("halted_flag", halted, 32'd1);
    chk("halted_ciclos", c_cyc, 32'd19);
    nxt(); taken = 1'b1; nxt(); nxt(); @(negedge clk);
    chk("ciclos_frozen", c_cyc, 32'd19);
    chk("halted_sticky", halted, 32'd1);
    // reset mid-drain
    nxt(); clr(); rst = 1'b0; nxt(); rst = 1'b1; @(negedge clk);
    chk("rst_unhalt", halted, 32'd0);
    nxt(); halt = 1'b1; nxt(); clr(); @(negedge clk); ctl("drain_b1", 4'b1011);
    nxt(); rst = 1'b0; @(negedge clk); ctl("rst_in_drain", 4'b0000);
    nxt(); rst = 1'b1; @(negedge clk);
    ctl("run_after_rst", 4'b0110);
    chk("ciclos_cleared", c_cyc, 32'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst    = ($urandom_range(0, 199) != 0);
      en     = ($urandom_range(0, 9) != 0);
      id_rs  = 5'($urandom_range(0, 3));
      id_rt  = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      usa_rs = 1'($urandom_range(0, 1));
      usa_rt = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      taken  = branch & 1'($urandom_range(0, 1));
      halt   = ($urandom_range(0, 79) == 0);
      ex_mr  = ($urandom_range(0, 3) == 0);
      ex_rw  = 1'($urandom_range(0, 1));
      mem_mr = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_riesgos_ctrl.md
Name: unidad_riesgos_ctrl

Overview:
- Hazard-control unit for the 5-stage MIPS pipeline.
- Generates i_Riesgo for the ID-stage control-bubble mux, plus PC/IF-ID write enables and the IF-ID flush.
- Sequences HALT: drains the pipeline after HALT reaches ID, then reports halted.
- Keeps debug counters (stalls, flushes, cycles) readable by the debug unit.

Parameters:
- DRAIN_CYCLES, 4, cycles from HALT in ID until it retires from WB.
- CNT_W, 32, width of each debug counter.

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  synchronous, active-low reset
- i_enable  input  1  debug-unit run/step enable; 0 freezes the unit and the pipeline front end
- i_id_rs  input  5  ID source register rs
- i_id_rt  input  5  ID source register rt
- i_id_usa_rs  input  1  ID instruction reads rs
- i_id_usa_rt  input  1  ID instruction reads rt
- i_id_branch  input  1  ID is BEQ/BNE/JR/JALR (operands compared/used in ID)
- i_id_taken  input  1  ID branch/jump resolved taken
- i_id_halt  input  1  HALT decoded in ID
- i_ex_memread  input  1  EX MemRead
- i_ex_regwrite  input  1  EX RegWrite
- i_ex_rd  input  5  EX destination register
- i_mem_memread  input  1  MEM MemRead
- i_mem_rd  input  5  MEM destination register
- o_riesgo  output  1  bubble request to ID control mux
- o_pc_write  output  1  PC write enable
- o_ifid_write  output  1  IF/ID write enable
- o_ifid_flush  output  1  IF/ID load NOP
- o_halted  output  1  pipeline drained after HALT (sticky)
- o_cnt_stall  output  CNT_W  stall cycles
- o_cnt_flush  output  CNT_W  flush cycles
- o_cnt_ciclos  output  CNT_W  enabled cycles before halted

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset → RUN.
- Reset: drain counter 0, all counters 0, o_halted 0. While i_reset=0, o_riesgo/o_pc_write/o_ifid_write/o_ifid_flush are forced to 0.
- match(r) = r!=0 && ((r==i_id_rs && i_id_usa_rs) || (r==i_id_rt && i_id_usa_rt)).
- stall, combinational, same cycle:
  - i_ex_memread && match(i_ex_rd), or
  - i_id_branch && i_ex_regwrite && match(i_ex_rd), or
  - i_id_branch && i_mem_memread && match(i_mem_rd).
- Resulting stall lengths: load→use is 1 cycle; ALU→branch is 1 cycle; load→branch is 2 cycles.
- RUN with i_enable=1:
  - stall → o_riesgo=1, o_pc_write=0, o_ifid_write=0, o_ifid_flush=0. i_id_taken and i_id_halt are ignored. cnt_stall++.
  - else if i_id_halt → o_pc_write=0, o_ifid_write=1, o_ifid_flush=1. Load drain counter = DRAIN_CYCLES-1; go to DRAIN. HALT itself passes to EX unbubbled.
  - else if i_id_taken → o_pc_write=1, o_ifid_write=1, o_ifid_flush=1. cnt_flush++.
  - else → o_pc_write=1, o_ifid_write=1, others 0.
- DRAIN:
  - o_pc_write=0, o_ifid_write=1, o_ifid_flush=1, o_riesgo=1. ID holds a NOP; hazards are ignored.
  - Drain counter decrements each enabled cycle.
  - At 0 → HALTED, with o_halted=1 from the next cycle.
- HALTED:
  - o_halted=1, o_pc_write=0, o_ifid_write=0, o_riesgo=1, o_ifid_flush=0.
  - Exits only on reset.
- i_enable=0 (any state): o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_riesgo=0. State, drain counter and all counters hold.
- cnt_ciclos increments each enabled cycle in RUN/DRAIN and freezes in HALTED.
- All counters saturate at 2^CNT_W-1 (no wrap).
- Priority: reset > !i_enable > stall > halt > taken.
- Reset asserted mid-DRAIN returns to RUN with counters cleared the next cycle.

Decomposition:
- Shared package riesgos_pkg: FSM state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), register-index width 5, default DRAIN_CYCLES.
- One sub-module, riesgos_detector: purely combinational stall equation. The FSM and counters stay in the top.

Test Plan:
- LW $2 in EX (ex_memread=1, ex_rd=2), ID rs=2 usa_rs=1 → 1 cycle o_riesgo=1, pc_write=0, ifid_write=0; cnt_stall=1. Same with ex_rd=0 → no stall.
- Load→BEQ: ex_memread, ex_rd=5, ID branch rt=5 → stall. Next cycle mem_memread, mem_rd=5 → stall again. Result: 2 cycles, cnt_stall=2. ADD→BEQ (ex_regwrite only) → exactly 1 stall.
- Taken branch with no hazard → o_ifid_flush=1, pc_write=1, cnt_flush=1. Taken while stalled → no flush, cnt_flush unchanged.
- HALT in ID with DRAIN_CYCLES=4 → flush in the halt cycle, DRAIN for 4 cycles, o_halted=1 on the 5th cycle. pc_write stays 0 throughout; cnt_ciclos frozen afterwards.
- i_enable=0 during a stall and during DRAIN → all enables 0. Drain counter and counters hold; sequence resumes identically when enable returns to 1.
- i_reset=0 for 1 cycle mid-DRAIN → state RUN, counters 0, o_halted 0, outputs forced 0 during reset. Normal fetch (pc_write=1) resumes after release.
